mem_burst_arbiter: RTL

- Two-requester arbiter and burst sequencer in front of the byte-addressed main memory block.
- Accepts one burst request at a time (1/4/8/16 words) from instruction fetch (requester 0) or data access (requester 1).
- Arbitrates round-robin and breaks each burst into single-word memory accesses with incrementing addresses.
- Returns read data with per-beat valid and signals completion; the memory only ever sees access_size 2'b00.

---
 rtl/mem_burst_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_burst_arbiter.sv
// Two-requester round-robin arbiter that splits 1/4/8/16-word bursts into single-word memory accesses.
// Optional range checking of each burst is enabled by defining MEM_ARB_RANGE_CHECK_EN.
module mem_burst_arbiter #(
  parameter logic [31:0] START_ADDR = 32'h8002_0000,
  parameter int unsigned DEPTH      = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  rw,
  input  logic [3:0]  size,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  beat_ack,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic        mem_busy,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_gnt;
  logic        r_owner;
  logic        r_last;
  logic        r_rw;
  logic        r_err;
  logic [31:0] r_base;
  logic [3:0]  r_beat;
  logic [3:0]  r_last_beat;
  logic [1:0]  r_rvalid;

  logic        w_pick;
  logic [1:0]  w_size;
  logic [31:0] w_base;
  logic [3:0]  w_last_beat;
  logic        w_issue;
  logic        w_oor;
  logic        w_range_err;
  logic [63:0] w_end;
  logic [63:0] w_limit;

  // Both requesting: the one that did not own the previous burst wins.
  assign w_pick = (req == 2'b11) ? ~r_last : req[1];
  assign w_size = w_pick ? size[3:2] : size[1:0];
  assign w_base = w_pick ? {addr[63:34], 2'b00} : {addr[31:2], 2'b00};

  always_comb begin
    case (w_size)
      2'b00:   w_last_beat = 4'd0;
      2'b01:   w_last_beat = 4'd3;
      2'b10:   w_last_beat = 4'd7;
      default: w_last_beat = 4'd15;
    endcase
  end

  assign w_end   = 64'(w_base) + (64'(w_last_beat) + 64'd1) * 64'd4;
  assign w_limit = 64'(START_ADDR) + 64'(DEPTH);
  assign w_oor   = (w_base < START_ADDR) || (w_end > w_limit);

`ifdef MEM_ARB_RANGE_CHECK_EN
  assign w_range_err = w_oor;
`else
  // Range logic stays elaborated but can never flag a burst.
  assign w_range_err = w_oor && 1'b0;
`endif

  assign w_issue = (r_state == BURST) && !mem_busy;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_next      = r_state;
    mem_enable  = 1'b0;
    mem_rw      = 1'b0;
    mem_address = 32'h0;
    beat_ack    = 2'b00;
    done        = 2'b00;
    err         = 2'b00;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) w_next = w_range_err ? DONE : BURST;
      end
      BURST: begin
        mem_enable  = 1'b1;
        mem_rw      = r_rw;
        mem_address = r_base + {26'd0, r_beat, 2'b00};
        beat_ack    = w_issue ? r_gnt : 2'b00;
        if (w_issue && (r_beat == r_last_beat)) w_next = r_rw ? DRAIN : DONE;
      end
      DRAIN: w_next = DONE;
      DONE: begin
        done   = r_gnt;
        err    = r_err ? r_gnt : 2'b00;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gnt       <= 2'b00;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_rw        <= 1'b0;
      r_err       <= 1'b0;
      r_base      <= 32'h0;
      r_beat      <= 4'd0;
      r_last_beat <= 4'd0;
      r_rvalid    <= 2'b00;
    end else begin
      r_state  <= w_next;
      r_rvalid <= (w_issue && r_rw) ? r_gnt : 2'b00;
      case (r_state)
        IDLE: begin
          if (req != 2'b00) begin
            r_owner     <= w_pick;
            r_gnt       <= {w_pick, ~w_pick};
            r_base      <= w_base;
            r_rw        <= w_pick ? rw[1] : rw[0];
            r_last_beat <= w_last_beat;
            r_beat      <= 4'd0;
            r_err       <= w_range_err;
          end
        end
        BURST: begin
          if (w_issue) r_beat <= r_beat + 4'd1;
        end
        DONE: begin
          r_gnt  <= 2'b00;
          r_last <= r_owner;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign gnt             = r_gnt;
  assign rvalid          = r_rvalid;
  assign rdata           = mem_data_out;
  assign mem_data_in     = r_owner ? wdata[63:32] : wdata[31:0];
  assign mem_access_size = 2'b00;

endmodule
